// File: rtl/pile_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pile_reader_pkg
// Description : Shared solitaire card definitions. Covers the card word
//               layout, suit codes, tableau pile ids and the tableau
//               capacity rule.
// Revision    : 1.0 - initial release
// ============================================================================
package pile_reader_pkg;

    localparam int NUM_TAB  = 7;
    localparam int BASE_CAP = 13;
    localparam int CARD_W   = 7;

    // Card word layout: [6:3] rank, [2:1] suit, [0] face-up
    localparam int RANK_MSB   = 6;
    localparam int RANK_LSB   = 3;
    localparam int SUIT_MSB   = 2;
    localparam int SUIT_LSB   = 1;
    localparam int FACEUP_BIT = 0;

    typedef logic [CARD_W-1:0] card_t;
    typedef logic [2:0]        pile_id_t;
    typedef logic [4:0]        slot_idx_t;

    typedef enum logic [1:0] {
        SPADES   = 2'd0,
        HEARTS   = 2'd1,
        DIAMONDS = 2'd2,
        CLUBS    = 2'd3
    } suit_e;

    localparam card_t      EMPTY_CARD = 7'h00;
    localparam logic [3:0] RANK_MAX   = 4'd13;

    localparam pile_id_t TAB1 = 3'd0;
    localparam pile_id_t TAB2 = 3'd1;
    localparam pile_id_t TAB3 = 3'd2;
    localparam pile_id_t TAB4 = 3'd3;
    localparam pile_id_t TAB5 = 3'd4;
    localparam pile_id_t TAB6 = 3'd5;
    localparam pile_id_t TAB7 = 3'd6;

    // Tableau t (pile id t-1) holds at most BASE_CAP+t-1 cards: 13..19
    function automatic slot_idx_t tab_capacity(input pile_id_t pile);
        return slot_idx_t'(BASE_CAP) + slot_idx_t'(pile);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pile_reader_if.sv
`default_nettype none
// ============================================================================
// Module      : pile_reader_if
// Description : Bus bundle for the pile reader. Carries the scan control
//               (start/busy/done/bad_card), the registered pile-storage read
//               port (rd_*), and the valid/ready card output stream (out_*).
//               Modport master = the reader, slave = its environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface pile_reader_if;
    import pile_reader_pkg::*;

    logic      start;
    logic      rd_en;
    pile_id_t  rd_pile;
    slot_idx_t rd_idx;
    card_t     rd_data;
    logic      out_valid;
    logic      out_ready;
    card_t     out_card;
    pile_id_t  out_pile;
    slot_idx_t out_idx;
    logic      out_last;
    logic      busy;
    logic      done;
    logic      bad_card;

    modport master (
        input  start, rd_data, out_ready,
        output rd_en, rd_pile, rd_idx,
        output out_valid, out_card, out_pile, out_idx, out_last,
        output busy, done, bad_card
    );

    modport slave (
        output start, rd_data, out_ready,
        input  rd_en, rd_pile, rd_idx,
        input  out_valid, out_card, out_pile, out_idx, out_last,
        input  busy, done, bad_card
    );

endinterface
`default_nettype wire

// File: rtl/pile_reader_card_check.sv
`default_nettype none
// ============================================================================
// Module      : card_check
// Description : Combinational card word classifier.
//               i_card         - card word
//               o_is_empty     - word is the empty-slot marker
//               o_is_malformed - non-empty word whose rank is 0 or above 13
// Revision    : 1.0 - initial release
// ============================================================================
module card_check
    import pile_reader_pkg::*;
(
    input  wire card_t i_card,
    output logic       o_is_empty,
    output logic       o_is_malformed
);

    logic [3:0] w_rank;

    assign w_rank         = i_card[RANK_MSB:RANK_LSB];
    assign o_is_empty     = (i_card == EMPTY_CARD);
    assign o_is_malformed = !o_is_empty && ((w_rank == 4'd0) || (w_rank > RANK_MAX));

endmodule
`default_nettype wire

// File: rtl/pile_reader.sv
`default_nettype none
// ============================================================================
// Module      : pile_reader
// Description : Walks tableau piles 1..7 out of pile storage after a start
//               pulse. Every occupied slot is emitted on a valid/ready card
//               stream with its pile, slot and an end-of-pile flag. A pile
//               ends at its first empty slot or at its capacity.
//   clk, rst  - clock, synchronous active-high reset
//   bus       - pile_reader_if.master: start/busy/done/bad_card control,
//               rd_en/rd_pile/rd_idx -> rd_data (one-cycle latency) storage
//               port, out_* card stream
// Revision    : 1.0 - initial release
// ============================================================================
module pile_reader
    import pile_reader_pkg::*;
(
    input  wire           clk,
    input  wire           rst,
    pile_reader_if.master bus
);

    localparam logic [2:0] c_st_idle = 3'd0;
    localparam logic [2:0] c_st_req  = 3'd1;
    localparam logic [2:0] c_st_wait = 3'd2;
    localparam logic [2:0] c_st_look = 3'd3;
    localparam logic [2:0] c_st_hold = 3'd4;
    localparam logic [2:0] c_st_done = 3'd5;

    logic [2:0] state_q,     state_d;
    pile_id_t   pile_q,      pile_d;
    slot_idx_t  idx_q,       idx_d;
    card_t      cand_q,      cand_d;      // card at (pile_q, idx_q)
    card_t      la_q,        la_d;        // lookahead word at idx_q+1
    logic       la_pend_q,   la_pend_d;   // lookahead read in flight
    logic       out_valid_q, out_valid_d;
    card_t      out_card_q,  out_card_d;
    pile_id_t   out_pile_q,  out_pile_d;
    slot_idx_t  out_idx_q,   out_idx_d;
    logic       out_last_q,  out_last_d;
    logic       out_bad_q,   out_bad_d;   // presented card is malformed
    logic       busy_q,      busy_d;
    logic       done_q,      done_d;
    logic       bad_card_q,  bad_card_d;

    logic       w_cand_empty;
    logic       w_cand_bad;
    logic       w_la_issue;
    logic       w_adv;
    logic       w_at_cap;
    slot_idx_t  w_idx_nxt;

    card_check u_cand_check (
        .i_card         (cand_q),
        .o_is_empty     (w_cand_empty),
        .o_is_malformed (w_cand_bad)
    );

    always_comb begin
        state_d     = state_q;
        pile_d      = pile_q;
        idx_d       = idx_q;
        cand_d      = cand_q;
        la_d        = la_q;
        la_pend_d   = la_pend_q;
        out_valid_d = out_valid_q;
        out_card_d  = out_card_q;
        out_pile_d  = out_pile_q;
        out_idx_d   = out_idx_q;
        out_last_d  = out_last_q;
        out_bad_d   = out_bad_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        bad_card_d  = bad_card_q;
        w_la_issue  = 1'b0;
        w_adv       = 1'b0;
        w_idx_nxt   = idx_q + 5'd1;
        w_at_cap    = (w_idx_nxt == tab_capacity(pile_q));

        case (state_q)
            c_st_idle: begin
                if (bus.start) begin
                    bad_card_d = 1'b0;
                    pile_d     = TAB1;
                    idx_d      = 5'd0;
                    busy_d     = 1'b1;
                    state_d    = c_st_req;
                end
            end

            c_st_req: begin
                state_d = c_st_wait;
            end

            c_st_wait: begin
                cand_d  = bus.rd_data;
                state_d = c_st_look;
            end

            c_st_look: begin
                if (w_cand_empty) begin
                    w_adv = 1'b1;
                end else if (la_pend_q) begin
                    // Lookahead word has arrived: present the candidate
                    la_d        = bus.rd_data;
                    la_pend_d   = 1'b0;
                    out_valid_d = 1'b1;
                    out_card_d  = cand_q;
                    out_pile_d  = pile_q;
                    out_idx_d   = idx_q;
                    out_last_d  = (bus.rd_data == EMPTY_CARD);
                    out_bad_d   = w_cand_bad;
                    state_d     = c_st_hold;
                end else if (w_at_cap) begin
                    // Last slot of the pile: no storage beyond it to read
                    out_valid_d = 1'b1;
                    out_card_d  = cand_q;
                    out_pile_d  = pile_q;
                    out_idx_d   = idx_q;
                    out_last_d  = 1'b1;
                    out_bad_d   = w_cand_bad;
                    state_d     = c_st_hold;
                end else begin
                    w_la_issue = 1'b1;
                    la_pend_d  = 1'b1;
                end
            end

            c_st_hold: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    if (out_bad_q) begin
                        bad_card_d = 1'b1;
                    end
                    if (out_last_q) begin
                        w_adv = 1'b1;
                    end else begin
                        // Reuse the lookahead word instead of re-reading it
                        cand_d  = la_q;
                        idx_d   = w_idx_nxt;
                        state_d = c_st_look;
                    end
                end
            end

            c_st_done: begin
                busy_d  = 1'b0;
                pile_d  = TAB1;
                idx_d   = 5'd0;
                state_d = c_st_idle;
            end

            default: begin
                state_d = c_st_idle;
            end
        endcase

        if (w_adv) begin
            if (pile_q == TAB7) begin
                done_d  = 1'b1;
                state_d = c_st_done;
            end else begin
                pile_d  = pile_q + 3'd1;
                idx_d   = 5'd0;
                state_d = c_st_req;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= c_st_idle;
            pile_q      <= '0;
            idx_q       <= '0;
            cand_q      <= '0;
            la_q        <= '0;
            la_pend_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_card_q  <= '0;
            out_pile_q  <= '0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
            out_bad_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            bad_card_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pile_q      <= pile_d;
            idx_q       <= idx_d;
            cand_q      <= cand_d;
            la_q        <= la_d;
            la_pend_q   <= la_pend_d;
            out_valid_q <= out_valid_d;
            out_card_q  <= out_card_d;
            out_pile_q  <= out_pile_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
            out_bad_q   <= out_bad_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            bad_card_q  <= bad_card_d;
        end
    end

    // The storage port reads idx_q on a fresh request and idx_q+1 on a lookahead
    assign bus.rd_en     = (state_q == c_st_req) || w_la_issue;
    assign bus.rd_pile   = pile_q;
    assign bus.rd_idx    = w_la_issue ? w_idx_nxt : idx_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_card  = out_card_q;
    assign bus.out_pile  = out_pile_q;
    assign bus.out_idx   = out_idx_q;
    assign bus.out_last  = out_last_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.bad_card  = bad_card_q;

endmodule
`default_nettype wire

// File: tb/tb_pile_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_pile_reader
// Description : Self-checking bench for pile_reader. Pile storage is a
//               behavioural array with a one-cycle read port. The expected
//               card stream is derived from the storage contents by walking
//               each pile until its first empty slot or its capacity.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pile_reader;
    import pile_reader_pkg::*;

    logic clk;
    logic rst;

    pile_reader_if bus ();

    pile_reader dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [6:0]  mem [7][32];
    logic [15:0] got_q [$];
    logic [15:0] exp_q [$];
    bit          exp_bad;
    int          n_vec;
    int          n_miss;
    int          rdy_mode;
    int          done_cnt;
    int          vld_cnt;
    int          bad_rd;
    int          stall_rd;
    int          stall_err;
    int          max_rd7;
    int          last_cycles;
    bit          rd_idx_nz;

    initial clk = 1'b0;
    initial forever #5 clk = ~clk;

    // Pile storage: registered read, data valid the cycle after rd_en
    initial begin
        bus.rd_data = '0;
        forever begin
            @(posedge clk);
            if (bus.rd_en) bus.rd_data <= mem[bus.rd_pile][bus.rd_idx];
        end
    end

    // Consumer ready: 0 always ready, 1 random, 3 stall on the first card of pile 3
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = 1'($urandom_range(0, 1));
                default: bus.out_ready = !(bus.out_valid && bus.out_pile == 3'd3);
            endcase
        end
    end

    function automatic bit legal_read(input logic [2:0] p, input logic [4:0] i);
        if (p > 3'd6 || int'(i) >= BASE_CAP + int'(p)) return 1'b0;
        for (int j = 0; j < int'(i); j++) begin
            if (mem[p][j] == 7'h00) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Bus observer
    initial begin
        bit          prev_stall;
        bit          prev_rst;
        logic [15:0] snap;
        logic [15:0] cur;
        prev_stall = 1'b0;
        prev_rst   = 1'b1;
        snap       = '0;
        forever begin
            @(negedge clk);
            cur = {bus.out_card, bus.out_pile, bus.out_idx, bus.out_last};
            if (!rst) begin
                if (bus.out_valid && bus.out_ready) got_q.push_back(cur);
                if (bus.out_valid) vld_cnt++;
                if (bus.done) done_cnt++;
                if (bus.busy && bus.rd_idx != 5'd0) rd_idx_nz = 1'b1;
                if (bus.rd_en) begin
                    if (!legal_read(bus.rd_pile, bus.rd_idx)) bad_rd++;
                    if (bus.out_valid && !bus.out_ready) stall_rd++;
                    if (bus.rd_pile == 3'd6 && int'(bus.rd_idx) > max_rd7) max_rd7 = int'(bus.rd_idx);
                end
                if (prev_stall && !prev_rst && (!bus.out_valid || cur !== snap)) stall_err++;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_rst   = rst;
            snap       = cur;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [28:0] rvec();
        return {bus.rd_en, bus.rd_pile, bus.rd_idx, bus.out_valid, bus.out_card,
                bus.out_pile, bus.out_idx, bus.out_last, bus.busy, bus.done, bus.bad_card};
    endfunction

    // Reference: each pile yields its leading run of non-empty slots, capped
    task automatic build_exp();
        int cap;
        int rank;
        logic [6:0] w;
        logic [6:0] nx;
        exp_q.delete();
        exp_bad = 1'b0;
        for (int p = 0; p < NUM_TAB; p++) begin
            cap = BASE_CAP + p;
            for (int i = 0; i < cap; i++) begin
                w = mem[p][i];
                if (w == 7'h00) break;
                nx = (i + 1 < cap) ? mem[p][i+1] : 7'h00;
                exp_q.push_back({w, 3'(p), 5'(i), (nx == 7'h00)});
                rank = int'(w) / 8;
                if (rank == 0 || rank > 13) exp_bad = 1'b1;
            end
        end
    endtask

    task automatic clear_stats();
        got_q.delete();
        done_cnt  = 0;
        vld_cnt   = 0;
        bad_rd    = 0;
        stall_rd  = 0;
        stall_err = 0;
        max_rd7   = -1;
        rd_idx_nz = 1'b0;
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    task automatic run_scan(input string tag);
        bit fin;
        build_exp();
        clear_stats();
        pulse_start();
        fin         = 1'b0;
        last_cycles = 0;
        while (last_cycles < 4000 && !fin) begin
            @(negedge clk);
            last_cycles++;
            if (last_cycles == 1) begin
                chk({tag, "_busy_at_start"}, bus.busy, 1);
                chk({tag, "_bad_cleared"}, bus.bad_card, 0);
            end
            if (bus.done) fin = 1'b1;
        end
        chk({tag, "_done_reached"}, fin, 1);
        chk({tag, "_bad_at_done"}, bus.bad_card, exp_bad);
        @(negedge clk);
        chk({tag, "_busy_after"}, bus.busy, 0);
        chk({tag, "_bad_held"}, bus.bad_card, exp_bad);
        chk({tag, "_done_count"}, done_cnt, 1);
        chk({tag, "_num_cards"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk($sformatf("%s_card%0d", tag, i), got_q[i], exp_q[i]);
        end
        chk({tag, "_illegal_reads"}, bad_rd, 0);
        chk({tag, "_stall_reads"}, stall_rd, 0);
        chk({tag, "_stall_stable"}, stall_err, 0);
    endtask

    task automatic fill_zero();
        for (int p = 0; p < 7; p++)
            for (int i = 0; i < 32; i++) mem[p][i] = 7'h00;
    endtask

    task automatic fill_plan();
        fill_zero();
        for (int t = 1; t <= 7; t++)
            for (int i = 0; i < t; i++) mem[t-1][i] = {4'(t), HEARTS, 1'b1};
    endtask

    task automatic fill_full7();
        fill_zero();
        for (int i = 0; i < 32; i++)
            mem[6][i] = {4'($urandom_range(1, 13)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1))};
    endtask

    task automatic fill_rand();
        int cap;
        int len;
        for (int p = 0; p < 7; p++) begin
            cap = BASE_CAP + p;
            len = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, cap));
            for (int i = 0; i < 32; i++) begin
                if (i >= cap || i < len) mem[p][i] = 7'($urandom_range(1, 127));
                else if (i == len)       mem[p][i] = 7'h00;
                else                     mem[p][i] = 7'($urandom_range(0, 127));
            end
        end
    endtask

    initial begin
        bit found;
        n_vec     = 0;
        n_miss    = 0;
        rdy_mode  = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        fill_zero();
        clear_stats();

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_state", rvec(), 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // t face-up hearts of rank t in tableau t
        fill_plan();
        run_scan("plan");
        chk("plan_total", got_q.size(), 28);

        // Everything empty: pure 3-cycle pile walk
        fill_zero();
        run_scan("empty");
        chk("empty_latency", last_cycles, 22);
        chk("empty_no_valid", vld_cnt, 0);
        chk("empty_rd_idx", rd_idx_nz, 0);

        // Start during the done cycle must not launch a new scan
        clear_stats();
        pulse_start();
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            @(negedge clk);
            if (bus.done) found = 1'b1;
        end
        chk("sad_done_seen", found, 1);
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(negedge clk);
        chk("start_at_done_ignored", bus.busy, 0);

        // Tableau 7 filled to capacity, with non-empty storage beyond it
        fill_full7();
        run_scan("full7");
        chk("full7_total", got_q.size(), 19);
        chk("full7_max_rd_idx", max_rd7, 18);
        if (got_q.size() > 0) chk("full7_last_idx", got_q[got_q.size()-1][5:0], {5'd18, 1'b1});

        // Malformed rank-15 word in pile 2
        fill_plan();
        mem[2][0] = 7'h09;
        mem[2][1] = 7'h78;
        mem[2][2] = 7'h00;
        run_scan("bad");
        chk("bad_flag", bus.bad_card, 1);

        // Random contents with a randomly stalling consumer
        rdy_mode = 1;
        for (int k = 0; k < 5; k++) begin
            fill_rand();
            run_scan($sformatf("rand%0d", k));
        end

        // Reset while holding the first card of pile 3
        rdy_mode = 3;
        fill_plan();
        clear_stats();
        pulse_start();
        found = 1'b0;
        for (int c = 0; c < 2000 && !found; c++) begin
            @(negedge clk);
            if (bus.out_valid && bus.out_pile == 3'd3) found = 1'b1;
        end
        chk("rst_reach_pile3", found, 1);
        repeat (3) @(negedge clk);
        chk("rst_hold_valid", bus.out_valid, 1);
        chk("rst_hold_fields", {bus.out_pile, bus.out_idx}, {3'd3, 5'd0});
        chk("rst_hold_no_reads", stall_rd, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_state", rvec(), 0);
        repeat (5) @(negedge clk);
        chk("rst_no_done", done_cnt, 0);
        chk("rst_idle", bus.busy, 0);

        // Fresh scan after the abort starts from pile 0, slot 0
        rdy_mode = 0;
        run_scan("rescan");
        if (got_q.size() > 0) chk("rescan_first", got_q[0][8:1], {3'd0, 5'd0});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
